// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: priority stall merge, exception/ERET
// flush with redirect PC, stall-cycle counter and a sticky stuck-stall watchdog.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter logic [31:0] RESET_PC     = 32'hBFC00000,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WDOG_LIMIT   = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic        exc_eret,
    input  logic [31:0] epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt,
    output logic        wdog_timeout
);

    // state | meaning
    // RUN   | normal operation, stall requests merged, exceptions accepted
    // FLUSH | pipeline registers cleared, all requests ignored

    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WDOG_MAX   = 16'(WDOG_LIMIT);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t      state;
    state_t      state_next;
    logic        take;
    logic [2:0]  flush_cnt;
    logic [15:0] wdog_cnt;

    always_comb begin
        state_next = state;
        stall      = 6'b000000;
        take       = 1'b0;
        case (state)
            ST_RUN: begin
                // stall is gated by rst so it reads zero while reset is asserted
                if (rst) begin
                    if (stallreq_mem)     stall = 6'b011111;
                    else if (stallreq_ex) stall = 6'b001111;
                    else if (stallreq_id) stall = 6'b000111;
                    else if (stallreq_if) stall = 6'b000011;
                end
                if (exc_valid && !stallreq_mem) begin
                    take       = 1'b1;
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == 3'd0) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            flush     <= 1'b0;
            flush_cnt <= 3'd0;
            new_pc    <= RESET_PC;
        end else begin
            state <= state_next;
            if (take) begin
                flush     <= 1'b1;
                flush_cnt <= FLUSH_LOAD;
                new_pc    <= exc_eret ? epc : EXC_VECTOR;
            end else if (state == ST_FLUSH) begin
                if (flush_cnt == 3'd0) flush <= 1'b0;
                else                   flush_cnt <= flush_cnt - 3'd1;
            end
        end
    end

    // stall[0] is zero throughout FLUSH, which also clears the watchdog run length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt    <= 32'd0;
            wdog_cnt     <= 16'd0;
            wdog_timeout <= 1'b0;
        end else if (stall[0]) begin
            stall_cnt <= stall_cnt + 32'd1;
            if (wdog_cnt != WDOG_MAX) wdog_cnt <= wdog_cnt + 16'd1;
            if (wdog_cnt + 16'd1 == WDOG_MAX) wdog_timeout <= 1'b1;
        end else begin
            wdog_cnt <= 16'd0;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes reference-model expectations each
// cycle, an independent monitor pops and compares against the DUT outputs.
module tb_pipeline_ctrl;

    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam logic [31:0] RST_PC  = 32'hBFC00000;
    localparam int          FC      = 3;
    localparam int          WL      = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        exc_valid = 1'b0, exc_eret = 1'b0;
    logic [31:0] epc = 32'd0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic        wdog_timeout;

    pipeline_ctrl #(
        .EXC_VECTOR(EXC_VEC), .RESET_PC(RST_PC), .FLUSH_CYCLES(FC), .WDOG_LIMIT(WL)
    ) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exc_valid(exc_valid), .exc_eret(exc_eret), .epc(epc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cnt(stall_cnt), .wdog_timeout(wdog_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        wd;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    // reference model state
    int          m_flush_left = 0;
    logic [31:0] m_pc  = RST_PC;
    logic [31:0] m_cnt = 32'd0;
    int          m_run = 0;
    logic        m_wd  = 1'b0;

    function automatic logic [5:0] held_mask(int stages);
        return 6'((1 << stages) - 1);
    endfunction

    task automatic cycle(input logic r, input logic i_if, input logic i_id, input logic i_ex,
                         input logic i_mem, input logic exc, input logic eret, input logic [31:0] pc_in);
        exp_t e;
        int   n;
        @(negedge clk);
        rst = r; stallreq_if = i_if; stallreq_id = i_id; stallreq_ex = i_ex;
        stallreq_mem = i_mem; exc_valid = exc; exc_eret = eret; epc = pc_in;
        if (!r) begin
            m_flush_left = 0; m_pc = RST_PC; m_cnt = 0; m_run = 0; m_wd = 1'b0;
        end
        // stages held = highest requesting stage index + 1 (PC counts as one)
        n = 0;
        if (r && m_flush_left == 0)
            n = i_mem ? 5 : i_ex ? 4 : i_id ? 3 : i_if ? 2 : 0;
        e.stall = held_mask(n);
        e.flush = (m_flush_left > 0);
        e.pc    = m_pc;
        e.cnt   = m_cnt;
        e.wd    = m_wd;
        q.push_back(e);
        if (r) begin
            if (m_flush_left > 0) m_flush_left--;
            else if (exc && !i_mem) begin
                m_flush_left = FC;
                m_pc = eret ? pc_in : EXC_VEC;
            end
            if (n > 0) begin
                m_cnt++;
                if (m_run < WL) m_run++;
                if (m_run >= WL) m_wd = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) cycle(1, 0, 0, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: outputs are presented every cycle, sampled 2 time units after negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(stall), 32'(e.stall));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("new_pc", new_pc, e.pc);
                chk("stall_cnt", stall_cnt, e.cnt);
                chk("wdog_timeout", 32'(wdog_timeout), 32'(e.wd));
            end
        end
    end

    initial begin
        logic r, a, b, c, d, x, y;
        cycle(0, 0, 0, 0, 0, 0, 0, 32'd0);
        cycle(0, 1, 1, 1, 1, 1, 0, 32'd0);
        idle(2);
        // priority merge
        cycle(1, 0, 1, 0, 0, 0, 0, 32'd0);
        cycle(1, 0, 1, 0, 1, 0, 0, 32'd0);
        cycle(1, 0, 0, 0, 0, 0, 0, 32'd0);
        cycle(1, 1, 0, 1, 0, 0, 0, 32'd0);
        // exception to vector, then flush with a pending EX stall request
        cycle(1, 0, 0, 0, 0, 1, 0, 32'h1234_5678);
        for (int j = 0; j < FC; j++) cycle(1, 0, 0, 1, 0, 1, 1, 32'hDEAD_BEEF);
        idle(2);
        // ERET blocked by MEM stall for 3 cycles
        for (int j = 0; j < 3; j++) cycle(1, 0, 0, 0, 1, 1, 1, 32'h8000_1234);
        cycle(1, 0, 0, 0, 0, 1, 1, 32'h8000_1234);
        idle(FC + 2);
        // watchdog trip and stickiness
        for (int j = 0; j < WL + 1; j++) cycle(1, 1, 0, 0, 0, 0, 0, 32'd0);
        idle(3);
        // reset in the middle of a flush
        cycle(1, 0, 0, 0, 0, 1, 0, 32'd0);
        cycle(1, 0, 0, 0, 0, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 32'd0);
        idle(3);
        // randomized traffic
        for (int j = 0; j < 3000; j++) begin
            r = ($urandom_range(0, 79) != 0);
            a = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 5) == 0);
            x = ($urandom_range(0, 9) == 0);
            y = $urandom_range(0, 1);
            cycle(r, a, b, c, d, x, y, $urandom);
        end
        idle(2);
        @(negedge clk);
        #5;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d required=0 pending expectations", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
